// File: rtl/mem_wb_writeback_pkg.sv
// Shared constants for the MEM->WB writeback stage: load-op encodings,
// FSM state codes and the load legality check.
package mem_wb_writeback_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int RADDR_W_DEF  = 5;
  localparam int LOADOP_W_DEF = 3;

  localparam logic [2:0] LOAD_LB  = 3'd0;
  localparam logic [2:0] LOAD_LBU = 3'd1;
  localparam logic [2:0] LOAD_LH  = 3'd2;
  localparam logic [2:0] LOAD_LHU = 3'd3;
  localparam logic [2:0] LOAD_LW  = 3'd4;

  localparam logic [0:0] WB_IDLE = 1'b0;
  localparam logic [0:0] WB_WAIT = 1'b1;

  // High when the load cannot be issued: reserved op or misaligned address.
  function automatic logic load_fault(input logic [2:0] op, input logic [1:0] addr_lo);
    case (op)
      LOAD_LB, LOAD_LBU: load_fault = 1'b0;
      LOAD_LH, LOAD_LHU: load_fault = addr_lo[0];
      LOAD_LW:           load_fault = (addr_lo != 2'b00);
      default:           load_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_writeback_load_align.sv
// Lane select and sign/zero extension of a little-endian loaded word.
module mem_wb_writeback_load_align
  import mem_wb_writeback_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOADOP_W = LOADOP_W_DEF
) (
  input  logic [DATA_W-1:0]   rdata,
  input  logic [LOADOP_W-1:0] op,
  input  logic [1:0]          addr_lo,
  output logic [DATA_W-1:0]   data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[8*addr_lo +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // NOTE: data gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    data = rdata;
    case (op)
      LOAD_LB:  data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LOAD_LBU: data = {{(DATA_W-8){1'b0}}, byte_sel};
      LOAD_LH:  data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LOAD_LHU: data = {{(DATA_W-16){1'b0}}, half_sel};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM->WB stage: registers ALU results into the register file write port and
// runs the req/ack load handshake with data memory, stalling upstream meanwhile.
module mem_wb_writeback
  import mem_wb_writeback_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RADDR_W  = RADDR_W_DEF,
  parameter int LOADOP_W = LOADOP_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_we,
  input  logic [RADDR_W-1:0]  in_waddr,
  input  logic [DATA_W-1:0]   in_result,
  input  logic                in_load,
  input  logic [LOADOP_W-1:0] in_load_op,
  input  logic                flush,
  output logic                dmem_req,
  output logic [DATA_W-1:0]   dmem_addr,
  input  logic                dmem_ack,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                stall_req,
  output logic                load_err,
  output logic                wb_we,
  output logic [RADDR_W-1:0]  wb_addr,
  output logic [DATA_W-1:0]   wb_data
);

  logic [0:0]          state;
  logic                killed;
  logic                cap_we;
  logic [RADDR_W-1:0]  cap_waddr;
  logic [LOADOP_W-1:0] cap_op;
  logic [1:0]          cap_lo;
  logic [DATA_W-1:0]   load_data;

  logic is_idle, is_wait, accept, fault, alu_go, load_go, load_bad;

  assign is_idle  = (state == WB_IDLE);
  assign is_wait  = (state == WB_WAIT);
  assign accept   = is_idle & in_valid & ~flush;
  assign fault    = load_fault(in_load_op, in_result[1:0]);
  assign alu_go   = accept & ~in_load;
  assign load_go  = accept & in_load & ~fault;
  assign load_bad = accept & in_load & fault;

  // Upstream advances on the ack-cycle edge, so the stall drops during the ack cycle.
  assign stall_req = (is_idle & in_valid & in_load & ~flush) | (is_wait & ~dmem_ack);

  mem_wb_writeback_load_align #(
    .DATA_W   (DATA_W),
    .LOADOP_W (LOADOP_W)
  ) u_load_align (
    .rdata   (dmem_rdata),
    .op      (cap_op),
    .addr_lo (cap_lo),
    .data    (load_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WB_IDLE;
      killed    <= 1'b0;
      cap_we    <= 1'b0;
      cap_waddr <= '0;
      cap_op    <= '0;
      cap_lo    <= '0;
      dmem_req  <= 1'b0;
      dmem_addr <= '0;
      load_err  <= 1'b0;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else begin
      // Writeback and error are single-cycle pulses; address/data read 0 when idle.
      wb_we    <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      load_err <= 1'b0;

      case (state)
        WB_IDLE: begin
          killed <= 1'b0;
          if (alu_go && in_we && (in_waddr != '0)) begin
            wb_we   <= 1'b1;
            wb_addr <= in_waddr;
            wb_data <= in_result;
          end
          if (load_go) begin
            state     <= WB_WAIT;
            dmem_req  <= 1'b1;
            dmem_addr <= {in_result[DATA_W-1:2], 2'b00};
            cap_we    <= in_we;
            cap_waddr <= in_waddr;
            cap_op    <= in_load_op;
            cap_lo    <= in_result[1:0];
          end
          if (load_bad) begin
            load_err <= 1'b1;
          end
        end

        WB_WAIT: begin
          if (flush) begin
            killed <= 1'b1;
          end
          // A flush in WAIT still lets the bus transaction finish; only the writeback is dropped.
          if (dmem_ack) begin
            state    <= WB_IDLE;
            dmem_req <= 1'b0;
            killed   <= 1'b0;
            if (cap_we && (cap_waddr != '0) && !killed && !flush) begin
              wb_we   <= 1'b1;
              wb_addr <= cap_waddr;
              wb_data <= load_data;
            end
          end
        end

        default: begin
          state    <= WB_IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
